// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader: FSM states, word geometry
// and the opcode constants used to build programs symbolically.
package instr_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

  // Instruction format: opcode[31:26] rd[25:21] rs[20:16] imm[15:0]
  localparam logic [5:0] OP_ADDI = 6'h01;
  localparam logic [5:0] OP_HALT = 6'h1A;
  localparam logic [5:0] OP_OUT  = 6'h1C;

  function automatic logic [31:0] encode_instr(input logic [5:0]  op,
                                               input logic [4:0]  rd,
                                               input logic [4:0]  rs,
                                               input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_packer.sv
// Assembles a big-endian word from a byte stream; flags the byte that completes
// a word and presents the full word combinationally alongside it.
module byte_packer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  byte_en_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [DATA_WIDTH-1:0] word_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-9:0] shift_q;

  // Earlier bytes shift toward the MSB, so the first byte ends up in the top lane.
  assign word_valid_o = byte_en_i & (idx_q == LAST_IDX);
  assign word_o       = {shift_q, byte_i};

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else if (byte_en_i) begin
      shift_q <= {shift_q[DATA_WIDTH-17:0], byte_i};
      idx_q   <= word_valid_o ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a program into instruction RAM one 32-bit word at a time, holding the
// CPU while loading and reporting completion or an oversize request.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  len_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                state_q;
  logic [ADDR_WIDTH:0]   word_cnt_q;
  logic [ADDR_WIDTH:0]   target_q;
  logic                  byte_ready_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  cpu_hold_q;
  logic                  done_q;
  logic                  len_err_q;

  logic                  accept;
  logic                  start_ok;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word;

  assign accept   = byte_valid & byte_ready_q;
  assign start_ok = start & (state_q != ST_LOAD);

  byte_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (start_ok),
    .byte_en_i    (accept),
    .byte_i       (byte_in),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      word_cnt_q   <= '0;
      target_q     <= '0;
      byte_ready_q <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (start_ok) begin
        word_cnt_q <= '0;
        done_q     <= 1'b0;
        len_err_q  <= 1'b0;
        if (word_count == '0) begin
          state_q      <= ST_DONE;
          done_q       <= 1'b1;
          cpu_hold_q   <= 1'b0;
          byte_ready_q <= 1'b0;
        end else if (word_count > DEPTH) begin
          state_q      <= ST_ERROR;
          len_err_q    <= 1'b1;
          cpu_hold_q   <= 1'b1;
          byte_ready_q <= 1'b0;
        end else begin
          state_q      <= ST_LOAD;
          target_q     <= word_count;
          cpu_hold_q   <= 1'b1;
          byte_ready_q <= 1'b1;
        end
      end else if (state_q == ST_LOAD && word_valid) begin
        wr_en_q    <= 1'b1;
        wr_addr_q  <= word_cnt_q[ADDR_WIDTH-1:0];
        wr_data_q  <= word;
        word_cnt_q <= word_cnt_q + 1'b1;
        // Last word: stop accepting in the same cycle its write strobe fires.
        if (word_cnt_q + 1'b1 == target_q) begin
          state_q      <= ST_DONE;
          byte_ready_q <= 1'b0;
          cpu_hold_q   <= 1'b0;
          done_q       <= 1'b1;
        end
      end
    end
  end

  assign byte_ready = byte_ready_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign cpu_hold   = cpu_hold_q;
  assign done       = done_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: random byte streams with gaps, checked against a
// model that expects word i of the program written at address i.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   word_count = '0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cpu_hold;
  logic          done;
  logic          len_err;

  instr_mem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .word_count (word_count),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          first_wr_cyc = -1;
  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [31:0] prog[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      got_q.push_back(wr_t'{addr: wr_addr, data: wr_data});
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] get_byte(input int i);
    logic [31:0] w;
    w = prog[i / 4];
    return w[31 - 8 * (i % 4) -: 8];
  endfunction

  // Reference model: word i of the program lands at address i, in order.
  task automatic build_expected(input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(wr_t'{addr: AW'(i), data: prog[i]});
  endtask

  task automatic random_prog(input int n);
    prog.delete();
    for (int i = 0; i < n; i++) prog.push_back($urandom);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_wr_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_wr_addr"}, got_q[i].addr, exp_q[i].addr);
      check({tag, "_wr_data"}, got_q[i].data, exp_q[i].data);
    end
    got_q.delete();
  endtask

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_start(input logic [AW:0] wc);
    start = 1'b1;
    word_count = wc;
    tick(1);
    start = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps.
  task automatic stream(input int mode, input int start_at, input int stop_after,
                        input int extra, output int word0_acc_cyc);
    int nb, idx, budget, n_extra;
    bit v, acc;
    nb = (stop_after >= 0) ? stop_after : prog.size() * 4;
    idx = 0;
    budget = 0;
    word0_acc_cyc = -1;
    while (idx < nb && budget < 20000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (budget % 2) == 0;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      byte_valid = v;
      byte_in = v ? get_byte(idx) : 8'($urandom);
      if (budget == start_at) begin
        start = 1'b1;
        word_count = '0;
      end
      @(negedge clk);
      acc = byte_valid && byte_ready;
      if (acc && idx == 3) word0_acc_cyc = cyc;
      tick(1);
      start = 1'b0;
      if (acc) idx++;
      budget++;
    end
    byte_valid = 1'b0;
    if (idx < nb) check("stream_timeout", idx, nb);
    n_extra = 0;
    for (int e = 0; e < extra; e++) begin
      byte_valid = 1'b1;
      byte_in = 8'($urandom);
      @(negedge clk);
      if (byte_ready) n_extra++;
      tick(1);
    end
    byte_valid = 1'b0;
    if (extra > 0) check("extra_bytes_taken", n_extra, 0);
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_byte_ready"}, byte_ready, 1'b0);
    check({tag, "_wr_en"}, wr_en, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_len_err"}, len_err, 1'b0);
    check({tag, "_cpu_hold"}, cpu_hold, 1'b1);
    check({tag, "_wr_addr"}, wr_addr, '0);
    check({tag, "_wr_data"}, wr_data, '0);
  endtask

  task automatic check_done(input string tag);
    @(negedge clk);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_cpu_hold"}, cpu_hold, 1'b0);
    check({tag, "_byte_ready"}, byte_ready, 1'b0);
    check({tag, "_len_err"}, len_err, 1'b0);
  endtask

  initial begin
    int acc0;
    int n;

    // Reset
    tick(2);
    check_reset_values("reset");
    rst_n = 1'b1;
    tick(1);

    // 1: six-word program, back-to-back
    prog.delete();
    prog.push_back(encode_instr(OP_ADDI, 5'd1, 5'd0, 16'd5));
    prog.push_back(encode_instr(OP_ADDI, 5'd1, 5'd1, 16'd1));
    prog.push_back(encode_instr(OP_ADDI, 5'd1, 5'd1, 16'd1));
    prog.push_back(encode_instr(OP_ADDI, 5'd1, 5'd1, 16'd1));
    prog.push_back(encode_instr(OP_OUT, 5'd0, 5'd0, 16'd0));
    prog.push_back(encode_instr(OP_HALT, 5'd0, 5'd0, 16'd0));
    check("t1_prog_word0", prog[0], 32'h0420_0005);
    got_q.delete();
    first_wr_cyc = -1;
    do_start(6);
    @(negedge clk);
    check("t1_byte_ready_first_load", byte_ready, 1'b1);
    check("t1_cpu_hold_load", cpu_hold, 1'b1);
    tick(1);
    stream(0, -1, -1, 0, acc0);
    tick(2);
    build_expected(6);
    compare_writes("t1");
    check("t1_first_wr_latency", first_wr_cyc, acc0 + 1);
    check_done("t1");
    tick(1);

    // 2: two words with byte_valid toggling every cycle
    prog = prog[0:1];
    do_start(2);
    stream(1, -1, -1, 0, acc0);
    tick(2);
    build_expected(2);
    compare_writes("t2");
    check_done("t2");
    tick(1);

    // 3: zero-length load
    do_start(0);
    @(negedge clk);
    check("t3_done", done, 1'b1);
    check("t3_cpu_hold", cpu_hold, 1'b0);
    check("t3_wr_en", wr_en, 1'b0);
    tick(1);
    for (int i = 0; i < 5; i++) begin
      byte_valid = 1'b1;
      byte_in = 8'($urandom);
      @(negedge clk);
      check("t3_byte_ready", byte_ready, 1'b0);
      tick(1);
    end
    byte_valid = 1'b0;
    exp_q.delete();
    compare_writes("t3");

    // 4: oversize request, then a legal one-word load
    do_start(11'd1025);
    @(negedge clk);
    check("t4_len_err", len_err, 1'b1);
    check("t4_cpu_hold", cpu_hold, 1'b1);
    check("t4_done", done, 1'b0);
    check("t4_byte_ready", byte_ready, 1'b0);
    tick(3);
    random_prog(1);
    do_start(1);
    @(negedge clk);
    check("t4_len_err_cleared", len_err, 1'b0);
    tick(1);
    stream(2, -1, -1, 0, acc0);
    tick(2);
    build_expected(1);
    compare_writes("t4");
    check_done("t4");
    tick(1);

    // 5: reset after two bytes of the second word
    random_prog(3);
    do_start(3);
    stream(0, -1, 6, 0, acc0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_reset_values("t5_mid_reset");
    tick(1);
    byte_valid = 1'b1;
    tick(10);
    byte_valid = 1'b0;
    build_expected(1);
    compare_writes("t5_partial");
    random_prog(1);
    do_start(1);
    stream(0, -1, -1, 0, acc0);
    tick(2);
    build_expected(1);
    compare_writes("t5_reload");
    check_done("t5");
    tick(1);

    // 6: start pulse mid-load, extra bytes after the last word
    random_prog(4);
    do_start(4);
    stream(2, 5, -1, 6, acc0);
    tick(2);
    build_expected(4);
    compare_writes("t6");
    check_done("t6");
    tick(1);

    // Random loads with random gaps
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 6);
      random_prog(n);
      do_start(AW'(n));
      stream(2, -1, -1, 2, acc0);
      tick(2);
      build_expected(n);
      compare_writes("rand");
      check_done("rand");
      tick(1);
    end

    // Full-depth load: last address must be 2**AW-1 with no wrap
    random_prog(1 << AW);
    do_start(11'd1024);
    stream(0, -1, -1, 2, acc0);
    tick(2);
    build_expected(1 << AW);
    compare_writes("full");
    check_done("full");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
